// File: rtl/spi_master_core.sv
// SPI mode-0 initiator: 8-bit full-duplex frames, multi-byte transactions framed by spi_tx_last.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first; the default build shifts MSB first.
`timescale 1ns/1ps
module spi_master_core #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] spi_tx_byte,
    input  logic       spi_tx_last,
    input  logic       spi_tx_valid,
    output logic       spi_tx_ready,
    output logic [7:0] spi_dat_recv,
    output logic       spi_dat_recv_dval,
    output logic       spi_busy,
    output logic       spi_clk,
    output logic       spi_ncs,
    output logic       spi_mosi,
    input  logic       spi_miso
);

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SMP_AT     = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic             last_q;
    logic             miso_meta;
    logic             miso_sync;

    logic             first_bit;
    logic             next_bit;
    logic [7:0]       tx_shifted;
    logic [7:0]       rx_next;
    logic             accept;

    assign accept = spi_tx_ready && spi_tx_valid;

    // tx_sr always holds the bit currently on spi_mosi at the end nearest the wire.
    always_comb begin
        if (LSB_FIRST) begin
            first_bit  = spi_tx_byte[0];
            tx_shifted = {1'b0, tx_sr[7:1]};
            next_bit   = tx_sr[1];
            rx_next    = {miso_sync, rx_sr[7:1]};
        end else begin
            first_bit  = spi_tx_byte[7];
            tx_shifted = {tx_sr[6:0], 1'b0};
            next_bit   = tx_sr[6];
            rx_next    = {rx_sr[6:0], miso_sync};
        end
    end

    // NOTE: every register below uses non-blocking assignment so all flops see pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bit_cnt           <= '0;
            tx_sr             <= '0;
            rx_sr             <= '0;
            last_q            <= 1'b0;
            miso_meta         <= 1'b0;
            miso_sync         <= 1'b0;
            spi_tx_ready      <= 1'b0;
            spi_dat_recv      <= '0;
            spi_dat_recv_dval <= 1'b0;
            spi_busy          <= 1'b0;
            spi_clk           <= 1'b0;
            spi_ncs           <= 1'b1;
            spi_mosi          <= 1'b0;
        end else begin
            miso_meta         <= spi_miso;
            miso_sync         <= miso_meta;
            spi_dat_recv_dval <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_sr        <= spi_tx_byte;
                        last_q       <= spi_tx_last;
                        spi_mosi     <= first_bit;
                        spi_ncs      <= 1'b0;
                        spi_busy     <= 1'b1;
                        spi_tx_ready <= 1'b0;
                        cnt          <= '0;
                        state        <= ST_SETUP;
                    end else begin
                        spi_tx_ready <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_SHIFT: begin
                    // Sample late in the high phase to absorb the two-flop miso synchroniser.
                    if (spi_clk && (cnt == SMP_AT)) begin
                        rx_sr <= rx_next;
                    end
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                        end else begin
                            spi_clk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                spi_dat_recv      <= rx_sr;
                                spi_dat_recv_dval <= 1'b1;
                                state             <= last_q ? ST_HOLD : ST_NEXT;
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                tx_sr    <= tx_shifted;
                                spi_mosi <= next_bit;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_NEXT: begin
                    // Ready rises one cycle after dval, so an accept never lands on the dval cycle.
                    if (accept) begin
                        tx_sr        <= spi_tx_byte;
                        last_q       <= spi_tx_last;
                        spi_mosi     <= first_bit;
                        spi_tx_ready <= 1'b0;
                        cnt          <= '0;
                        bit_cnt      <= '0;
                        state        <= ST_SHIFT;
                    end else begin
                        spi_tx_ready <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        spi_ncs  <= 1'b1;
                        spi_mosi <= 1'b0;
                        state    <= ST_GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    if (cnt == IDLE_LAST) begin
                        cnt      <= '0;
                        spi_busy <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
